// File: rtl/ws2812_seq_pkg.sv
// ============================================================================
// Module   : ws2812_seq_pkg
// Brief    : Shared types and address maps for the WS2812 frame sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ws2812_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CFG  = 3'd1,
        ST_LOAD = 3'd2,
        ST_KICK = 3'd3,
        ST_WAIT = 3'd4,
        ST_HOLD = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        M_IDLE   = 2'd0,
        M_SETUP  = 2'd1,
        M_ACCESS = 2'd2
    } mst_state_t;

    // CPU-facing register offsets
    localparam logic [5:0] C_REG_CTRL   = 6'h00;
    localparam logic [5:0] C_REG_PERIOD = 6'h04;
    localparam logic [5:0] C_REG_BUF    = 6'h08;
    localparam logic [5:0] C_REG_STATUS = 6'h0C;
    localparam logic [5:0] C_REG_BRIGHT = 6'h10;

    localparam int C_CTRL_EN      = 0;
    localparam int C_CTRL_ONESHOT = 1;
    localparam int C_CTRL_IRQ_EN  = 2;

    // WS2812 peripheral offsets and CONTROL bits
    localparam logic [5:0] C_PER_STATUS    = 6'h00;
    localparam logic [5:0] C_PER_CONTROL   = 6'h04;
    localparam logic [5:0] C_PER_COLOUR_WR = 6'h08;

    localparam int C_PCTRL_AUTO_SEND = 0;
    localparam int C_PCTRL_SEND      = 1;

    function automatic logic [23:0] scale_rgb(input logic [23:0] rgb, input logic [7:0] bright);
        logic [15:0] f;
        logic [15:0] r;
        logic [15:0] g;
        logic [15:0] b;
        f = {8'd0, bright} + 16'd1;
        r = ({8'd0, rgb[23:16]} * f) >> 8;
        g = ({8'd0, rgb[15:8]}  * f) >> 8;
        b = ({8'd0, rgb[7:0]}   * f) >> 8;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ws2812_apb_master.sv
// ============================================================================
// Module   : ws2812_apb_master
// Brief    : Single-write APB master; one start pulse issues one transfer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_apb_master
    import ws2812_seq_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        start_i,
    input  logic [5:0]  addr_i,
    input  logic [31:0] data_i,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [5:0]  paddr_o,
    output logic [31:0] pwdata_o,
    input  logic        pready_i,
    input  logic        pslverr_i,
    output logic        done_o,
    output logic        err_o
);

    mst_state_t  r_state;
    mst_state_t  w_next;
    logic [5:0]  r_addr;
    logic [31:0] r_data;

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= M_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            M_IDLE:   if (start_i) w_next = M_SETUP;
            M_SETUP:  w_next = M_ACCESS;
            M_ACCESS: if (pready_i) w_next = M_IDLE;
            default:  w_next = M_IDLE;
        endcase
    end

    always_comb begin
        psel_o    = (r_state != M_IDLE);
        penable_o = (r_state == M_ACCESS);
        pwrite_o  = 1'b1;
        done_o    = (r_state == M_ACCESS) && pready_i;
        err_o     = (r_state == M_ACCESS) && pready_i && pslverr_i;
    end

    // Address/data captured at start so the requester may change them freely
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_addr <= '0;
            r_data <= '0;
        end else if ((r_state == M_IDLE) && start_i) begin
            r_addr <= addr_i;
            r_data <= data_i;
        end
    end

    assign paddr_o  = r_addr;
    assign pwdata_o = r_data;

endmodule

`default_nettype wire

// File: rtl/ws2812_frame_sequencer.sv
// ============================================================================
// Module   : ws2812_frame_sequencer
// Brief    : Refreshes a WS2812 peripheral over APB from a local frame buffer.
//            Optional WS2812_SEQ_BRIGHTNESS_EN adds a global brightness scaler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ws2812_frame_sequencer
    import ws2812_seq_pkg::*;
#(
    parameter int LED_COUNT    = 3,
    parameter int DONE_TIMEOUT = 2000000
)(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        s_apb_psel_i,
    input  logic        s_apb_penable_i,
    input  logic        s_apb_pwrite_i,
    input  logic [5:0]  s_apb_paddr_i,
    input  logic [31:0] s_apb_pwdata_i,
    output logic [31:0] s_apb_prdata_o,
    output logic        s_apb_pready_o,
    output logic        s_apb_pslverr_o,
    output logic        m_apb_psel_o,
    output logic        m_apb_penable_o,
    output logic        m_apb_pwrite_o,
    output logic [5:0]  m_apb_paddr_o,
    output logic [31:0] m_apb_pwdata_o,
    input  logic        m_apb_pready_i,
    input  logic        m_apb_pslverr_i,
    input  logic        led_done_i,
    output logic        irq_o
);

    localparam int                 C_IDX_W        = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX     = C_IDX_W'(LED_COUNT - 1);
    localparam logic [8:0]         C_LED_COUNT    = 9'(LED_COUNT);
    localparam logic [31:0]        C_TIMEOUT_LAST = 32'(DONE_TIMEOUT - 1);

    logic               r_s_pready;
    logic               r_s_pslverr;
    logic [31:0]        r_s_prdata;
    logic [2:0]         r_ctrl;
    logic [23:0]        r_period;
    logic               r_err_slv;
    logic               r_err_to;
    logic [7:0]         r_frame_cnt;
    logic               r_irq;
    logic [23:0]        r_buf [LED_COUNT];
    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [C_IDX_W-1:0] r_idx;
    logic               r_issued;
    logic [31:0]        r_wait_cnt;
    logic [23:0]        r_timer;

    logic               w_s_access;
    logic               w_s_err;
    logic               w_wr_ok;
    logic [31:0]        w_rdata;
    logic [7:0]         w_buf_idx;
    logic               w_idx_ok;
    logic               w_timer_expired;
    logic               w_m_start;
    logic [5:0]         w_m_addr;
    logic [31:0]        w_m_data;
    logic               w_m_done;
    logic               w_m_err;
    logic               w_frame_done;
    logic               w_err_slv;
    logic               w_err_to;
    logic               w_cfg_entry;
    logic               w_busy;
    logic [23:0]        w_led_rgb;

`ifdef WS2812_SEQ_BRIGHTNESS_EN
    logic [7:0]         r_bright;
`endif

    // Each access is answered once; the completing cycle itself is not re-accepted
    assign w_s_access = s_apb_psel_i && s_apb_penable_i && !r_s_pready;
    assign w_buf_idx  = s_apb_pwdata_i[31:24];
    assign w_idx_ok   = ({1'b0, w_buf_idx} < C_LED_COUNT);
    assign w_wr_ok    = w_s_access && s_apb_pwrite_i && !w_s_err;

    always_comb begin
        w_s_err = 1'b0;
        w_rdata = '0;
        case (s_apb_paddr_i)
            C_REG_CTRL:   w_rdata = {29'd0, r_ctrl};
            C_REG_PERIOD: w_rdata = {8'd0, r_period};
            C_REG_BUF:    w_s_err = !s_apb_pwrite_i || !w_idx_ok;
            C_REG_STATUS: w_rdata = {16'd0, r_frame_cnt, 5'd0, r_err_to, r_err_slv, w_busy};
`ifdef WS2812_SEQ_BRIGHTNESS_EN
            C_REG_BRIGHT: w_rdata = {24'd0, r_bright};
`endif
            default:      w_s_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_s_pready  <= 1'b0;
            r_s_pslverr <= 1'b0;
            r_s_prdata  <= '0;
        end else begin
            r_s_pready  <= w_s_access;
            r_s_pslverr <= w_s_access && w_s_err;
            if (w_s_access) begin
                r_s_prdata <= (!s_apb_pwrite_i && !w_s_err) ? w_rdata : '0;
            end
        end
    end

    assign s_apb_pready_o  = r_s_pready;
    assign s_apb_pslverr_o = r_s_pslverr;
    assign s_apb_prdata_o  = r_s_prdata;

    // Sequencer events take priority over a same-cycle CPU write
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_ctrl      <= '0;
            r_period    <= '0;
            r_err_slv   <= 1'b0;
            r_err_to    <= 1'b0;
            r_frame_cnt <= '0;
            r_irq       <= 1'b0;
        end else begin
            if (w_wr_ok && (s_apb_paddr_i == C_REG_CTRL))   r_ctrl   <= s_apb_pwdata_i[2:0];
            if (w_wr_ok && (s_apb_paddr_i == C_REG_PERIOD)) r_period <= s_apb_pwdata_i[23:0];
            if (w_cfg_entry)            r_ctrl[C_CTRL_ONESHOT] <= 1'b0;
            if (w_err_slv || w_err_to)  r_ctrl[C_CTRL_EN]      <= 1'b0;
            if (w_wr_ok && (s_apb_paddr_i == C_REG_STATUS) && s_apb_pwdata_i[1]) r_err_slv <= 1'b0;
            if (w_wr_ok && (s_apb_paddr_i == C_REG_STATUS) && s_apb_pwdata_i[2]) r_err_to  <= 1'b0;
            if (w_err_slv)    r_err_slv   <= 1'b1;
            if (w_err_to)     r_err_to    <= 1'b1;
            if (w_frame_done) r_frame_cnt <= r_frame_cnt + 8'd1;
            r_irq <= r_ctrl[C_CTRL_IRQ_EN] && (w_frame_done || w_err_slv || w_err_to);
        end
    end

    assign irq_o = r_irq;

`ifdef WS2812_SEQ_BRIGHTNESS_EN
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_bright <= 8'hFF;
        end else if (w_wr_ok && (s_apb_paddr_i == C_REG_BRIGHT)) begin
            r_bright <= s_apb_pwdata_i[7:0];
        end
    end
    assign w_led_rgb = scale_rgb(r_buf[r_idx], r_bright);
`else
    assign w_led_rgb = r_buf[r_idx];
`endif

    // Buffer contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (w_wr_ok && (s_apb_paddr_i == C_REG_BUF)) begin
            r_buf[w_buf_idx[C_IDX_W-1:0]] <= s_apb_pwdata_i[23:0];
        end
    end

    // Expiry looks one cycle ahead so frame starts land exactly PERIOD clocks apart
    assign w_timer_expired = (({1'b0, r_timer} + 25'd1) >= {1'b0, r_period});

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_timer <= '0;
        end else if (w_cfg_entry) begin
            r_timer <= '0;
        end else if (r_timer != 24'hFF_FFFF) begin
            r_timer <= r_timer + 24'd1;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (r_ctrl[C_CTRL_ONESHOT] || (r_ctrl[C_CTRL_EN] && w_timer_expired)) w_next = ST_CFG;
            ST_CFG:  if (w_m_done) w_next = w_m_err ? ST_IDLE : ST_LOAD;
            ST_LOAD: begin
                if (w_m_done && w_m_err)                    w_next = ST_IDLE;
                else if (w_m_done && (r_idx == C_LAST_IDX)) w_next = ST_KICK;
            end
            ST_KICK: if (w_m_done) w_next = w_m_err ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
                if (led_done_i)    w_next = ST_HOLD;
                else if (w_err_to) w_next = ST_IDLE;
            end
            ST_HOLD: if (w_timer_expired) w_next = r_ctrl[C_CTRL_EN] ? ST_CFG : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
        w_cfg_entry = (w_next == ST_CFG) && (r_state != ST_CFG);
    end

    always_comb begin
        w_busy       = (r_state != ST_IDLE);
        w_m_start    = 1'b0;
        w_m_addr     = C_PER_CONTROL;
        w_m_data     = '0;
        case (r_state)
            ST_CFG:  w_m_start = !r_issued;
            ST_LOAD: begin
                w_m_start = !r_issued;
                w_m_addr  = C_PER_COLOUR_WR;
                w_m_data  = {8'(r_idx), w_led_rgb};
            end
            ST_KICK: begin
                w_m_start = !r_issued;
                w_m_data  = 32'd1 << C_PCTRL_SEND;
            end
            default: ;
        endcase
        w_frame_done = (r_state == ST_WAIT) && led_done_i;
        w_err_to     = (r_state == ST_WAIT) && !led_done_i && (r_wait_cnt == C_TIMEOUT_LAST);
        w_err_slv    = w_m_done && w_m_err;
    end

    // One transfer per visit; r_issued re-arms when the master reports done
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_issued   <= 1'b0;
            r_idx      <= '0;
            r_wait_cnt <= '0;
        end else begin
            if (w_m_start)     r_issued <= 1'b1;
            else if (w_m_done) r_issued <= 1'b0;
            if (r_state != ST_LOAD) r_idx <= '0;
            else if (w_m_done && !w_m_err && (r_idx != C_LAST_IDX)) r_idx <= r_idx + 1'b1;
            if (r_state != ST_WAIT) r_wait_cnt <= '0;
            else                    r_wait_cnt <= r_wait_cnt + 32'd1;
        end
    end

    ws2812_apb_master u_master (
        .clk_i     (clk_i),
        .resetn_i  (resetn_i),
        .start_i   (w_m_start),
        .addr_i    (w_m_addr),
        .data_i    (w_m_data),
        .psel_o    (m_apb_psel_o),
        .penable_o (m_apb_penable_o),
        .pwrite_o  (m_apb_pwrite_o),
        .paddr_o   (m_apb_paddr_o),
        .pwdata_o  (m_apb_pwdata_o),
        .pready_i  (m_apb_pready_i),
        .pslverr_i (m_apb_pslverr_i),
        .done_o    (w_m_done),
        .err_o     (w_m_err)
    );

endmodule

`default_nettype wire

// File: tb/tb_ws2812_frame_sequencer.sv
// ============================================================================
// Module   : tb_ws2812_frame_sequencer
// Brief    : Directed self-checking bench with a simple WS2812 peripheral model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ws2812_frame_sequencer;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_psel = 1'b0, s_pen = 1'b0, s_pwrite = 1'b0;
    logic [5:0]  s_paddr = '0;
    logic [31:0] s_pwdata = '0;
    logic [31:0] s_prdata;
    logic        s_pready, s_pslverr;
    logic        m_psel, m_pen, m_pwrite;
    logic [5:0]  m_paddr;
    logic [31:0] m_pwdata;
    logic        m_pready = 1'b0, m_pslverr = 1'b0;
    logic        led_done;
    logic        irq;

    logic        auto_pulse = 1'b0, manual_done = 1'b0, auto_done = 1'b0;
    int          err_at = -1, done_cnt = 0, cyc = 0;
    int          irq_cnt = 0, irq_wide = 0, irq_cyc = 0, kick_cyc = 0, bad_write = 0, n_apb_to = 0;
    logic        irq_prev = 1'b0;
    logic [37:0] log_q[$];
    int          cfg_cyc[$];
    int          n_chk = 0, n_fail = 0;

    assign led_done = auto_pulse | manual_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ws2812_frame_sequencer #(.LED_COUNT(3), .DONE_TIMEOUT(100)) dut (
        .clk_i(clk), .resetn_i(resetn),
        .s_apb_psel_i(s_psel), .s_apb_penable_i(s_pen), .s_apb_pwrite_i(s_pwrite),
        .s_apb_paddr_i(s_paddr), .s_apb_pwdata_i(s_pwdata), .s_apb_prdata_o(s_prdata),
        .s_apb_pready_o(s_pready), .s_apb_pslverr_o(s_pslverr),
        .m_apb_psel_o(m_psel), .m_apb_penable_o(m_pen), .m_apb_pwrite_o(m_pwrite),
        .m_apb_paddr_o(m_paddr), .m_apb_pwdata_o(m_pwdata),
        .m_apb_pready_i(m_pready), .m_apb_pslverr_i(m_pslverr),
        .led_done_i(led_done), .irq_o(irq)
    );

    // Zero-wait-state peripheral: logs writes, optional error, auto done pulse
    always @(negedge clk) begin
        if (m_psel && m_pen && !m_pready) begin
            m_pready  = 1'b1;
            m_pslverr = (log_q.size() == err_at);
            if (!m_pwrite) bad_write++;
            log_q.push_back({m_paddr, m_pwdata});
            if (m_paddr == 6'h04 && m_pwdata == 32'd0) cfg_cyc.push_back(cyc);
            if (m_paddr == 6'h04 && m_pwdata == 32'd2) begin
                kick_cyc = cyc;
                if (auto_done) done_cnt = 5;
            end
        end else begin
            m_pready  = 1'b0;
            m_pslverr = 1'b0;
        end
        auto_pulse = 1'b0;
        if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) auto_pulse = 1'b1;
        end
        if (irq) begin
            irq_cnt++;
            irq_cyc = cyc;
            if (irq_prev) irq_wide++;
        end
        irq_prev = irq;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic apb_xfer(input logic wr, input logic [5:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err);
        int n;
        @(negedge clk);
        s_psel = 1'b1; s_pen = 1'b0; s_pwrite = wr; s_paddr = a; s_pwdata = d;
        @(negedge clk);
        s_pen = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!s_pready && n < 8);
        if (!s_pready) n_apb_to++;
        rd  = s_prdata;
        err = s_pslverr;
        s_psel = 1'b0; s_pen = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [5:0] a, input logic [31:0] d, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, rd, err);
        chk_eq(tag, 64'(err), 64'(exp_err));
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b1, a, d, rd, err);
    endtask

    task automatic rd_chk(input string tag, input logic [5:0] a, input logic [31:0] exp, input logic exp_err);
        logic [31:0] rd;
        logic        err;
        apb_xfer(1'b0, a, 32'd0, rd, err);
        chk_eq(tag, {31'd0, err, rd}, {31'd0, exp_err, exp});
    endtask

    task automatic wait_irq(input string tag, input int target, input int limit);
        int n = 0;
        while (irq_cnt < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 64'(irq_cnt), 64'(target));
    endtask

    task automatic wait_log(input string tag, input int target, input int limit);
        int n = 0;
        while (log_q.size() < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_eq(tag, 64'(log_q.size()), 64'(target));
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] rd;
        logic        err;
        int          n = 0;
        do begin
            apb_xfer(1'b0, 6'h0C, 32'd0, rd, err);
            n++;
        end while (rd[0] && n < 1000);
        chk_eq(tag, 64'(rd[0]), 64'd0);
    endtask

    int b;

    initial begin
        repeat (3) @(negedge clk);
        chk_eq("reset_slave_outs", {s_prdata, s_pready, s_pslverr}, 64'd0);
        chk_eq("reset_master_outs", {m_psel, m_pen, irq, m_paddr, m_pwdata}, 64'd0);
        resetn = 1'b1;

        rd_chk("ctrl_reset", 6'h00, 32'd0, 1'b0);
        @(negedge clk);
        chk_eq("pready_one_cycle", 64'(s_pready), 64'd0);
        rd_chk("period_reset", 6'h04, 32'd0, 1'b0);
        rd_chk("status_reset", 6'h0C, 32'd0, 1'b0);
`ifdef WS2812_SEQ_BRIGHTNESS_EN
        rd_chk("bright_reset", 6'h10, 32'h0000_00FF, 1'b0);
`else
        rd_chk("bright_unmapped", 6'h10, 32'd0, 1'b1);
`endif

        wr_chk("wr_period", 6'h04, 32'd1000, 1'b0);
        rd_chk("period_rb", 6'h04, 32'd1000, 1'b0);
        wr_chk("wr_buf0", 6'h08, 32'h00FF_0000, 1'b0);
        wr_chk("wr_buf1", 6'h08, 32'h0100_FF00, 1'b0);
        wr_chk("wr_buf2", 6'h08, 32'h0200_00FF, 1'b0);
        wr_chk("wr_buf_idx3", 6'h08, 32'h03AB_CDEF, 1'b1);
        rd_chk("rd_buf_err", 6'h08, 32'd0, 1'b1);
        rd_chk("rd_unmapped", 6'h14, 32'd0, 1'b1);

        // Periodic frames
        auto_done = 1'b1;
        wr(6'h00, 32'h5);
        wait_log("frame1_writes", 5, 3000);
        chk_eq("f1_cfg",  log_q[0], {6'h04, 32'h0000_0000});
        chk_eq("f1_led0", log_q[1], {6'h08, 32'h00FF_0000});
        chk_eq("f1_led1", log_q[2], {6'h08, 32'h0100_FF00});
        chk_eq("f1_led2", log_q[3], {6'h08, 32'h0200_00FF});
        chk_eq("f1_kick", log_q[4], {6'h04, 32'h0000_0002});
        wait_irq("frame1_irq", 1, 100);
        rd_chk("status_f1", 6'h0C, 32'h0000_0101, 1'b0);
        wait_log("frame2_cfg", 6, 2000);
        chk_eq("period_spacing", 64'(cfg_cyc[1] - cfg_cyc[0]), 64'd1000);
        wr(6'h00, 32'h4);
        wait_irq("frame2_irq", 2, 200);
        wait_idle("stop_idle");
        rd_chk("status_stopped", 6'h0C, 32'h0000_0200, 1'b0);
        chk_eq("no_frame3", 64'(log_q.size()), 64'd10);

        // Peripheral error on the second colour write
        b = log_q.size();
        err_at = b + 2;
        wr(6'h00, 32'h5);
        wait_irq("err_slv_irq", 3, 3000);
        repeat (20) @(negedge clk);
        chk_eq("err_no_kick", 64'(log_q.size()), 64'(b + 3));
        rd_chk("status_err_slv", 6'h0C, 32'h0000_0202, 1'b0);
        rd_chk("ctrl_en_cleared", 6'h00, 32'h4, 1'b0);
        wr(6'h0C, 32'h2);
        rd_chk("err_slv_clear", 6'h0C, 32'h0000_0200, 1'b0);

        // Done withheld: timeout
        err_at = -1;
        auto_done = 1'b0;
        b = log_q.size();
        wr(6'h00, 32'h6);
        wait_irq("timeout_irq", 4, 3000);
        chk_eq("timeout_kick", log_q[b + 4], {6'h04, 32'h0000_0002});
        chk_eq("timeout_latency", 64'(irq_cyc - kick_cyc), 64'd101);
        rd_chk("status_timeout", 6'h0C, 32'h0000_0204, 1'b0);
        rd_chk("ctrl_oneshot_clr", 6'h00, 32'h4, 1'b0);

        // Done outside WAIT is ignored
        @(negedge clk); manual_done = 1'b1;
        @(negedge clk); manual_done = 1'b0;
        repeat (3) @(negedge clk);
        rd_chk("done_ignored", 6'h0C, 32'h0000_0204, 1'b0);
        wr(6'h0C, 32'h4);
        rd_chk("err_to_clear", 6'h0C, 32'h0000_0200, 1'b0);

`ifdef WS2812_SEQ_BRIGHTNESS_EN
        wr(6'h10, 32'h7F);
        rd_chk("bright_rb", 6'h10, 32'h7F, 1'b0);
        wr(6'h08, 32'h00FF_8002);
        auto_done = 1'b1;
        b = log_q.size();
        wr(6'h00, 32'h6);
        wait_irq("bright_irq", 5, 3000);
        chk_eq("bright_led0", log_q[b + 1], {6'h08, 32'h007F_4001});
        chk_eq("bright_led1", log_q[b + 2], {6'h08, 32'h0100_7F00});
`endif

        chk_eq("irq_single_cycle", 64'(irq_wide), 64'd0);
        chk_eq("master_pwrite", 64'(bad_write), 64'd0);
        chk_eq("slave_ready_timeouts", 64'(n_apb_to), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
